// File: rtl/ipg_msg_rx_extract.sv
// XGMII RX-side IPG message extractor: strips out-of-frame message blocks from the
// MAC-bound stream (replacing them with idles) and queues their payload on AXI-Stream.
module ipg_msg_rx_extract #(
  parameter int         DATA_WIDTH    = 64,
  parameter int         CTRL_WIDTH    = 8,
  parameter logic [7:0] MSG_CHAR      = 8'h5C,
  parameter int         MAX_MSG_BEATS = 16,
  parameter int         FIFO_DEPTH    = 32
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst,
  input  logic [DATA_WIDTH-1:0] xgmii_rxd_in,
  input  logic [CTRL_WIDTH-1:0] xgmii_rxc_in,
  output logic [DATA_WIDTH-1:0] xgmii_rxd_out,
  output logic [CTRL_WIDTH-1:0] xgmii_rxc_out,
  output logic [47:0]           m_axis_msg_tdata,
  output logic [5:0]            m_axis_msg_tkeep,
  output logic                  m_axis_msg_tvalid,
  input  logic                  m_axis_msg_tready,
  output logic                  m_axis_msg_tlast,
  output logic                  m_axis_msg_tuser,
  output logic                  rx_msg_err_seq,
  output logic                  rx_msg_err_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(MAX_MSG_BEATS + 1);
  localparam logic [63:0] IDLE_D = {8{8'h07}};

  typedef struct packed {
    logic [47:0] data;
    logic [5:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  typedef enum logic [1:0] {S_IDLE, S_MSG, S_DROP} state_t;

  // Stage 1: frame tracking, extraction, registered passthrough
  logic [63:0] rxd_out_d, rxd_out_q;
  logic [7:0]  rxc_out_d, rxc_out_q;
  logic        in_frame_d, in_frame_q;
  logic        msg_vld_d, msg_vld_q;
  logic [52:0] msg_blk_d, msg_blk_q;
  logic        is_msg, start, term;

  always_comb begin
    is_msg = (xgmii_rxc_in == 8'h01) && (xgmii_rxd_in[7:0] == MSG_CHAR) && !in_frame_q;
    start  = (xgmii_rxc_in[0] && xgmii_rxd_in[7:0] == 8'hFB) ||
             (xgmii_rxc_in[4] && xgmii_rxd_in[39:32] == 8'hFB);
    term   = 1'b0;
    for (int i = 0; i < 8; i++)
      if (xgmii_rxc_in[i] && xgmii_rxd_in[8*i +: 8] == 8'hFD) term = 1'b1;
    // A start in lane 4 after a terminate in the same block leaves us in-frame.
    in_frame_d = start ? 1'b1 : (term ? 1'b0 : in_frame_q);
    rxd_out_d  = is_msg ? IDLE_D : xgmii_rxd_in;
    rxc_out_d  = is_msg ? 8'hFF : xgmii_rxc_in;
    msg_vld_d  = is_msg;
    msg_blk_d  = {xgmii_rxd_in[63:16], xgmii_rxd_in[15:14], xgmii_rxd_in[10:8]};
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      rxd_out_q  <= IDLE_D;
      rxc_out_q  <= 8'hFF;
      in_frame_q <= 1'b0;
      msg_vld_q  <= 1'b0;
      msg_blk_q  <= '0;
    end else begin
      rxd_out_q  <= rxd_out_d;
      rxc_out_q  <= rxc_out_d;
      in_frame_q <= in_frame_d;
      msg_vld_q  <= msg_vld_d;
      msg_blk_q  <= msg_blk_d;
    end
  end

  assign xgmii_rxd_out = rxd_out_q;
  assign xgmii_rxc_out = rxc_out_q;

  // Stage 2: message FSM feeding the FIFO
  state_t          state_d, state_q;
  logic [BW-1:0]   beats_d, beats_q;
  logic [CW-1:0]   count_d, count_q;
  logic [AW-1:0]   wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic            err_seq_d, err_seq_q, err_ovf_d, err_ovf_q;
  logic            push, pop, first, last, cnt_ok, has_room;
  logic [2:0]      cnt;
  logic [5:0]      keep;
  beat_t           push_beat, head;
  beat_t           mem_q [FIFO_DEPTH];

  always_comb begin
    first    = msg_blk_q[4];
    last     = msg_blk_q[3];
    cnt      = msg_blk_q[2:0];
    cnt_ok   = last ? (cnt != 3'd0 && cnt <= 3'd6) : (cnt == 3'd6);
    keep     = 6'((7'd1 << cnt) - 7'd1);
    // Reserve a whole worst-case message at FIRST so nothing can overflow mid-message.
    has_room = count_q <= CW'(FIFO_DEPTH - MAX_MSG_BEATS - 1);

    state_d   = state_q;
    beats_d   = beats_q;
    push      = 1'b0;
    err_seq_d = 1'b0;
    err_ovf_d = 1'b0;
    push_beat.data = msg_blk_q[52:5];
    push_beat.keep = keep;
    push_beat.last = last;
    push_beat.user = 1'b0;

    case (state_q)
      S_IDLE: if (msg_vld_q) begin
        if (!first) err_seq_d = 1'b1;
        else if (!cnt_ok) begin
          err_seq_d = 1'b1;
          if (!last) state_d = S_DROP;
        end else if (has_room) begin
          push    = 1'b1;
          beats_d = BW'(1);
          if (!last) state_d = S_MSG;
        end else begin
          err_ovf_d = 1'b1;
          if (!last) state_d = S_DROP;
        end
      end
      S_MSG: if (msg_vld_q && !first && cnt_ok) begin
        push    = 1'b1;
        beats_d = beats_q + BW'(1);
        if (last) state_d = S_IDLE;
        else if (beats_q == BW'(MAX_MSG_BEATS - 1)) begin
          push_beat.last = 1'b1;
          push_beat.user = 1'b1;
          state_d        = S_DROP;
        end
      end else begin
        push      = 1'b1;
        push_beat = '{data: '0, keep: '0, last: 1'b1, user: 1'b1};
        err_seq_d = 1'b1;
        state_d   = (msg_vld_q && first && !last) ? S_DROP : S_IDLE;
      end
      S_DROP: if (!msg_vld_q || last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    pop      = m_axis_msg_tvalid && m_axis_msg_tready;
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state_q   <= S_IDLE;
      beats_q   <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_seq_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beats_q   <= beats_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      err_seq_q <= err_seq_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  always_ff @(posedge rx_clk)
    if (push) mem_q[wr_ptr_q] <= push_beat;

  // Storage is not reset, so outputs are masked while the FIFO is empty.
  assign head                = mem_q[rd_ptr_q];
  assign m_axis_msg_tvalid   = count_q != '0;
  assign m_axis_msg_tdata    = m_axis_msg_tvalid ? head.data : '0;
  assign m_axis_msg_tkeep    = m_axis_msg_tvalid ? head.keep : '0;
  assign m_axis_msg_tlast    = m_axis_msg_tvalid && head.last;
  assign m_axis_msg_tuser    = m_axis_msg_tvalid && head.user;
  assign rx_msg_err_seq      = err_seq_q;
  assign rx_msg_err_overflow = err_ovf_q;
endmodule

// File: tb/tb_ipg_msg_rx_extract.sv
// Directed bench for ipg_msg_rx_extract: XGMII path checked inline, AXI beats via scoreboard.
module tb_ipg_msg_rx_extract;
  localparam logic [63:0] IDL = 64'h0707070707070707;

  logic        clk = 1'b0, rst = 1'b1;
  logic [63:0] rxd_in = IDL, rxd_out;
  logic [7:0]  rxc_in = 8'hFF, rxc_out;
  logic [47:0] tdata;
  logic [5:0]  tkeep;
  logic        tvalid, tready = 1'b1, tlast, tuser, err_seq, err_ovf;

  ipg_msg_rx_extract dut (
    .rx_clk(clk), .rx_rst(rst),
    .xgmii_rxd_in(rxd_in), .xgmii_rxc_in(rxc_in),
    .xgmii_rxd_out(rxd_out), .xgmii_rxc_out(rxc_out),
    .m_axis_msg_tdata(tdata), .m_axis_msg_tkeep(tkeep), .m_axis_msg_tvalid(tvalid),
    .m_axis_msg_tready(tready), .m_axis_msg_tlast(tlast), .m_axis_msg_tuser(tuser),
    .rx_msg_err_seq(err_seq), .rx_msg_err_overflow(err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct { logic [47:0] d; logic [5:0] k; logic l; logic u; } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0, n_bad = 0, seq_cnt = 0, ovf_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat
  always @(negedge clk) if (!rst) begin
    if (err_seq) seq_cnt++;
    if (err_ovf) ovf_cnt++;
    if (tvalid && tready) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL beat_unexpected: got data %h keep %h last %b user %b, expected none",
                 tdata, tkeep, tlast, tuser);
      end else begin
        mon_e = q.pop_front();
        chk("tdata", 64'(tdata), 64'(mon_e.d));
        chk("tkeep", 64'(tkeep), 64'(mon_e.k));
        chk("tlast", 64'(tlast), 64'(mon_e.l));
        chk("tuser", 64'(tuser), 64'(mon_e.u));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc(input logic [63:0] d, input logic [7:0] c,
                     input logic [63:0] ed, input logic [7:0] ec, input string nm);
    rxd_in = d; rxc_in = c;
    @(posedge clk); #1;
    chk({nm, "_rxd"}, rxd_out, ed);
    chk({nm, "_rxc"}, 64'(rxc_out), 64'(ec));
  endtask

  task automatic idle();
    cyc(IDL, 8'hFF, IDL, 8'hFF, "idle");
  endtask

  task automatic msg(input logic [7:0] hdr, input logic [47:0] pl);
    cyc({pl, hdr, 8'h5C}, 8'h01, IDL, 8'hFF, "msg");
  endtask

  task automatic expb(input logic [47:0] d, input logic [5:0] k, input logic l, input logic u);
    exp_t e;
    e.d = d; e.k = k; e.l = l; e.u = u;
    q.push_back(e);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 300 && (q.size() != 0 || tvalid); i++) @(posedge clk);
    #1;
    chk({nm, "_drained"}, 64'(q.size()), 64'd0);
  endtask

  task automatic passthru(input logic [63:0] d, input logic [7:0] c);
    cyc(d, c, d, c, "passthru");
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rxd", rxd_out, IDL);
    chk("rst_rxc", 64'(rxc_out), 64'hFF);
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_tkeep", 64'(tkeep), 64'd0);
    chk("rst_tlast_tuser", 64'({tlast, tuser}), 64'd0);
    chk("rst_err", 64'({err_seq, err_ovf}), 64'd0);
    rst = 1'b0;
    idle(); idle();

    // Single-block message
    expb(48'h0000_00AA_BBCC, 6'h07, 1'b1, 1'b0);
    msg(8'hC3, 48'h0000_00AA_BBCC);
    idle(); idle();
    drain("single");

    // Three-block message
    expb(48'h1111_2222_3333, 6'h3F, 1'b0, 1'b0);
    expb(48'h4444_5555_6666, 6'h3F, 1'b0, 1'b0);
    expb(48'h0000_0000_7788, 6'h03, 1'b1, 1'b0);
    msg(8'h86, 48'h1111_2222_3333);
    msg(8'h06, 48'h4444_5555_6666);
    msg(8'h42, 48'h0000_0000_7788);
    idle();
    drain("three");

    // Message pattern inside frames (lane-0 and lane-4 starts) must pass untouched
    passthru(64'hD5555555555555FB, 8'h01);
    passthru({48'h1234_5678_9ABC, 8'hC3, 8'h5C}, 8'h01);
    passthru(64'h07070707070707FD, 8'hFF);
    passthru(64'h555555FB07070707, 8'h1F);
    passthru({48'hDEAD_BEEF_0001, 8'hC6, 8'h5C}, 8'h01);
    passthru(64'h0707070707FD0000, 8'hFC);
    // Frame closed: extraction resumes
    expb(48'h0000_0000_00EE, 6'h01, 1'b1, 1'b0);
    msg(8'hC1, 48'h0000_0000_00EE);
    idle();
    drain("inframe");

    // 20-block message: 16 beats, last one truncated
    for (int i = 1; i <= 20; i++) begin
      if (i <= 16) expb(48'(i) * 48'h0101_0101_0101, 6'h3F, i == 16, i == 16);
      msg(i == 1 ? 8'h86 : (i == 20 ? 8'h46 : 8'h06), 48'(i) * 48'h0101_0101_0101);
    end
    idle(); idle();
    drain("long");

    // Idle inside a message: abort marker and one sequence error
    expb(48'hA1A1_A1A1_A1A1, 6'h3F, 1'b0, 1'b0);
    expb(48'hB2B2_B2B2_B2B2, 6'h3F, 1'b0, 1'b0);
    expb(48'h0, 6'h00, 1'b1, 1'b1);
    msg(8'h86, 48'hA1A1_A1A1_A1A1);
    msg(8'h06, 48'hB2B2_B2B2_B2B2);
    idle(); idle(); idle();
    drain("abort");
    chk("err_seq_abort", 64'(seq_cnt), 64'd1);
    chk("err_ovf_none", 64'(ovf_cnt), 64'd0);

    // Overflow: fill to 15 entries (free = 17 still accepted), then 18 (free 14 rejected)
    tready = 1'b0;
    for (int m = 0; m < 4; m++) begin
      int nb;
      nb = (m < 2) ? 6 : 3;
      for (int b = 0; b < nb; b++) begin
        expb({40'h0, 8'(16 * m + b)}, 6'h3F, b == nb - 1, 1'b0);
        msg(b == 0 ? 8'h86 : (b == nb - 1 ? 8'h46 : 8'h06), {40'h0, 8'(16 * m + b)});
      end
      idle();
    end
    msg(8'h86, 48'hBAD0);
    msg(8'h06, 48'hBAD1);
    msg(8'h41, 48'hBAD2);
    idle(); idle(); idle();
    chk("err_ovf_pulse", 64'(ovf_cnt), 64'd1);
    chk("err_seq_overflow", 64'(seq_cnt), 64'd1);
    chk("held_tvalid", 64'(tvalid), 64'd1);
    chk("held_tdata", 64'(tdata), 64'h0);
    tready = 1'b1;
    drain("overflow");
    expb(48'h0000_0000_1122, 6'h03, 1'b1, 1'b0);
    msg(8'hC2, 48'h0000_0000_1122);
    idle(); idle();
    drain("after_ovf");

    // Async reset in the middle of a message clears everything
    tready = 1'b0;
    msg(8'h86, 48'h5555_5555_5555);
    msg(8'h06, 48'h6666_6666_6666);
    idle();
    chk("pre_rst_tvalid", 64'(tvalid), 64'd1);
    rst = 1'b1;
    #1;
    q.delete();
    chk("arst_tvalid", 64'(tvalid), 64'd0);
    chk("arst_tdata", 64'(tdata), 64'd0);
    chk("arst_tkeep", 64'(tkeep), 64'd0);
    chk("arst_tlast_tuser", 64'({tlast, tuser}), 64'd0);
    chk("arst_rxd", rxd_out, IDL);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tready = 1'b1;
    // FSM must be back in IDLE: a fresh single-block message is accepted cleanly
    expb(48'h0000_00CA_FE01, 6'h07, 1'b1, 1'b0);
    msg(8'hC3, 48'h0000_00CA_FE01);
    idle(); idle();
    drain("after_rst");
    chk("err_seq_final", 64'(seq_cnt), 64'd1);
    chk("err_ovf_final", 64'(ovf_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
